// File: rtl/vtg_pkg.sv
// Shared constants for the raster timing generator: register map and power-on timing.
package vtg_pkg;

  localparam int HW_DEF = 9;
  localparam int VW_DEF = 9;

  typedef enum logic [2:0] {
    ADDR_HLEN = 3'd0,
    ADDR_HBLK = 3'd1,
    ADDR_HSS  = 3'd2,
    ADDR_HSE  = 3'd3,
    ADDR_VLEN = 3'd4,
    ADDR_VBLK = 3'd5,
    ADDR_VSS  = 3'd6,
    ADDR_VSE  = 3'd7
  } reg_addr_e;

  localparam logic [8:0] HLEN_RST = 9'd383;
  localparam logic [8:0] HBLK_RST = 9'd256;
  localparam logic [8:0] HSS_RST  = 9'd300;
  localparam logic [8:0] HSE_RST  = 9'd332;
  localparam logic [8:0] VLEN_RST = 9'd311;
  localparam logic [8:0] VBLK_RST = 9'd200;
  localparam logic [8:0] VSS_RST  = 9'd250;
  localparam logic [8:0] VSE_RST  = 9'd253;

endpackage

// File: rtl/vtg_if.sv
// Control/status bundle between the timing generator and its host.
interface vtg_if
  import vtg_pkg::*;
#(
  parameter int HW = HW_DEF,
  parameter int VW = VW_DEF
);
  logic          CE;
  logic          REG_WR;
  logic [2:0]    REG_ADDR;
  logic [8:0]    REG_DATA;
  logic [HW-1:0] HCNT;
  logic [VW-1:0] VCNT;
  logic          HSYNCL;
  logic          VSYNCL;
  logic          BLANK;
  logic          EOL;
  logic          EOF;

  modport master (
    output CE, REG_WR, REG_ADDR, REG_DATA,
    input  HCNT, VCNT, HSYNCL, VSYNCL, BLANK, EOL, EOF
  );

  modport slave (
    input  CE, REG_WR, REG_ADDR, REG_DATA,
    output HCNT, VCNT, HSYNCL, VSYNCL, BLANK, EOL, EOF
  );
endinterface

// File: rtl/vtg_axis.sv
// One raster axis: wrapping counter plus sync/blank flags decoded from the pre-step count.
module vtg_axis #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         step_i,
  input  logic [W-1:0] len_i,
  input  logic [W-1:0] blk_i,
  input  logic [W-1:0] ss_i,
  input  logic [W-1:0] se_i,
  output logic [W-1:0] cnt_o,
  output logic         sync_o,
  output logic         blank_o,
  output logic         carry_o
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         sync_q, sync_d;
  logic         blank_q, blank_d;
  logic         wrap;

  // A shrunken LEN below the live count still ends the axis when the counter rolls over.
  assign wrap = (cnt_q == len_i) || (cnt_q == '1);

  always_comb begin
    // NOTE: every _d is given its hold value first so no path can infer a latch.
    cnt_d   = cnt_q;
    sync_d  = sync_q;
    blank_d = blank_q;
    if (step_i) begin
      cnt_d = wrap ? '0 : cnt_q + ONE;
      if (cnt_q == se_i)      sync_d = 1'b0;
      else if (cnt_q == ss_i) sync_d = 1'b1;
      if (wrap)                blank_d = 1'b0;
      else if (cnt_q == blk_i) blank_d = 1'b1;
    end
  end

  // NOTE: non-blocking updates so every flop samples the pre-edge state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      sync_q  <= 1'b0;
      blank_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      sync_q  <= sync_d;
      blank_q <= blank_d;
    end
  end

  assign cnt_o   = cnt_q;
  assign sync_o  = sync_q;
  assign blank_o = blank_q;
  assign carry_o = wrap;

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: timing register file, horizontal/vertical axes, blank and strobes.
module video_timing_gen
  import vtg_pkg::*;
#(
  parameter int HW = HW_DEF,
  parameter int VW = VW_DEF
) (
  input logic  MasterClock,
  input logic  RESETL,
  vtg_if.slave bus
);

  logic [HW-1:0] hlen_q, hblk_q, hss_q, hse_q;
  logic [VW-1:0] vlen_q, vblk_q, vss_q, vse_q;

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic          hsync, hblank, hwrap;
  logic          vsync, vblank, vwrap;
  logic          vstep;
  logic          eol_q, eol_d;
  logic          eof_q, eof_d;

  // NOTE: the timing registers carry power-on defaults, so they sit on the async reset.
  always_ff @(posedge MasterClock or negedge RESETL) begin
    if (!RESETL) begin
      hlen_q <= HLEN_RST[HW-1:0];
      hblk_q <= HBLK_RST[HW-1:0];
      hss_q  <= HSS_RST[HW-1:0];
      hse_q  <= HSE_RST[HW-1:0];
      vlen_q <= VLEN_RST[VW-1:0];
      vblk_q <= VBLK_RST[VW-1:0];
      vss_q  <= VSS_RST[VW-1:0];
      vse_q  <= VSE_RST[VW-1:0];
    end else if (bus.REG_WR) begin
      unique case (reg_addr_e'(bus.REG_ADDR))
        ADDR_HLEN: hlen_q <= bus.REG_DATA[HW-1:0];
        ADDR_HBLK: hblk_q <= bus.REG_DATA[HW-1:0];
        ADDR_HSS:  hss_q  <= bus.REG_DATA[HW-1:0];
        ADDR_HSE:  hse_q  <= bus.REG_DATA[HW-1:0];
        ADDR_VLEN: vlen_q <= bus.REG_DATA[VW-1:0];
        ADDR_VBLK: vblk_q <= bus.REG_DATA[VW-1:0];
        ADDR_VSS:  vss_q  <= bus.REG_DATA[VW-1:0];
        ADDR_VSE:  vse_q  <= bus.REG_DATA[VW-1:0];
      endcase
    end
  end

  vtg_axis #(.W(HW)) u_haxis (
    .clk     (MasterClock),
    .rst_n   (RESETL),
    .step_i  (bus.CE),
    .len_i   (hlen_q),
    .blk_i   (hblk_q),
    .ss_i    (hss_q),
    .se_i    (hse_q),
    .cnt_o   (hcnt),
    .sync_o  (hsync),
    .blank_o (hblank),
    .carry_o (hwrap)
  );

  // Lines advance only on the pixel step that ends a line.
  assign vstep = bus.CE & hwrap;

  vtg_axis #(.W(VW)) u_vaxis (
    .clk     (MasterClock),
    .rst_n   (RESETL),
    .step_i  (vstep),
    .len_i   (vlen_q),
    .blk_i   (vblk_q),
    .ss_i    (vss_q),
    .se_i    (vse_q),
    .cnt_o   (vcnt),
    .sync_o  (vsync),
    .blank_o (vblank),
    .carry_o (vwrap)
  );

  assign eol_d = vstep;
  assign eof_d = vstep & vwrap;

  always_ff @(posedge MasterClock or negedge RESETL) begin
    if (!RESETL) begin
      eol_q <= 1'b0;
      eof_q <= 1'b0;
    end else begin
      eol_q <= eol_d;
      eof_q <= eof_d;
    end
  end

  assign bus.HCNT   = hcnt;
  assign bus.VCNT   = vcnt;
  assign bus.HSYNCL = ~hsync;
  assign bus.VSYNCL = ~vsync;
  assign bus.BLANK  = hblank | vblank;
  assign bus.EOL    = eol_q;
  assign bus.EOF    = eof_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench: constant table, hand-written corner sequences and a randomized run vs. a model.
module tb_video_timing_gen;
  import vtg_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  vtg_if #(.HW(9), .VW(9)) bus ();

  video_timing_gen #(.HW(9), .VW(9)) dut (
    .MasterClock (clk),
    .RESETL      (rst_n),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: raster position and flags as plain integers.
  int m_reg[8];
  int m_h, m_v;
  bit m_hs, m_vs, m_hb, m_vb, m_eol, m_eof;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dut_vec();
    logic [31:0] v;
    v = '0;
    v[22:0] = {bus.HCNT, bus.VCNT, bus.HSYNCL, bus.VSYNCL, bus.BLANK, bus.EOL, bus.EOF};
    return v;
  endfunction

  function automatic logic [31:0] model_vec();
    logic [31:0] v;
    v = '0;
    v[22:14] = m_h[8:0];
    v[13:5]  = m_v[8:0];
    v[4]     = !m_hs;
    v[3]     = !m_vs;
    v[2]     = m_hb | m_vb;
    v[1]     = m_eol;
    v[0]     = m_eof;
    return v;
  endfunction

  task automatic model_reset();
    m_reg[0] = int'(HLEN_RST); m_reg[1] = int'(HBLK_RST);
    m_reg[2] = int'(HSS_RST);  m_reg[3] = int'(HSE_RST);
    m_reg[4] = int'(VLEN_RST); m_reg[5] = int'(VBLK_RST);
    m_reg[6] = int'(VSS_RST);  m_reg[7] = int'(VSE_RST);
    m_h = 0; m_v = 0;
    m_hs = 0; m_vs = 0; m_hb = 0; m_vb = 0; m_eol = 0; m_eof = 0;
  endtask

  // A line ends at HLEN or when the count would leave the 0..511 range.
  task automatic model_step(input bit ce, input bit wr, input int addr, input int data);
    bit line_end, frame_end;
    line_end  = (m_h == m_reg[0]) || (m_h + 1 == 512);
    frame_end = (m_v == m_reg[4]) || (m_v + 1 == 512);
    m_eol = ce && line_end;
    m_eof = ce && line_end && frame_end;
    if (ce) begin
      if (line_end) begin
        if (m_v == m_reg[7])      m_vs = 0;
        else if (m_v == m_reg[6]) m_vs = 1;
        if (frame_end)            m_vb = 0;
        else if (m_v == m_reg[5]) m_vb = 1;
        m_v = frame_end ? 0 : m_v + 1;
      end
      if (m_h == m_reg[3])      m_hs = 0;
      else if (m_h == m_reg[2]) m_hs = 1;
      if (line_end)             m_hb = 0;
      else if (m_h == m_reg[1]) m_hb = 1;
      m_h = line_end ? 0 : m_h + 1;
    end
    if (wr) m_reg[addr] = data;
  endtask

  // Inputs change on the falling edge; outputs are compared on the next falling edge.
  task automatic tick(input bit ce, input bit wr = 1'b0,
                      input logic [2:0] addr = 3'd0, input logic [8:0] data = 9'd0);
    bus.CE       = ce;
    bus.REG_WR   = wr;
    bus.REG_ADDR = addr;
    bus.REG_DATA = data;
    @(posedge clk);
    model_step(ce, wr, int'(addr), int'(data));
    @(negedge clk);
    bus.REG_WR = 1'b0;
    check("model", dut_vec(), model_vec());
  endtask

  task automatic do_reset();
    bus.CE = 1'b0; bus.REG_WR = 1'b0; bus.REG_ADDR = '0; bus.REG_DATA = '0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_reset", dut_vec(), 32'h0000_0018);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick(1'b1);
  endtask

  typedef struct {
    int n;
    int hcnt;
    int vcnt;
    bit hsyncl;
    bit blank;
    bit eol;
  } vec_t;

  vec_t tbl[10];

  initial begin
    bit saw_low;
    int edges;

    tbl[0] = '{1,   1,   0, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{256, 256, 0, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{257, 257, 0, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{300, 300, 0, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{301, 301, 0, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{332, 332, 0, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{333, 333, 0, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{383, 383, 0, 1'b1, 1'b1, 1'b0};
    tbl[8] = '{384, 0,   1, 1'b1, 1'b0, 1'b1};
    tbl[9] = '{385, 1,   1, 1'b1, 1'b0, 1'b0};

    // Default timing, CE every cycle, checked at fixed edge counts after reset.
    do_reset();
    edges = 0;
    for (int i = 0; i < 10; i++) begin
      while (edges < tbl[i].n) begin
        tick(1'b1);
        edges++;
      end
      check("tbl_hcnt",   32'(bus.HCNT),   32'(tbl[i].hcnt));
      check("tbl_vcnt",   32'(bus.VCNT),   32'(tbl[i].vcnt));
      check("tbl_hsyncl", 32'(bus.HSYNCL), 32'(tbl[i].hsyncl));
      check("tbl_blank",  32'(bus.BLANK),  32'(tbl[i].blank));
      check("tbl_eol",    32'(bus.EOL),    32'(tbl[i].eol));
    end

    // Hold with CE low mid-sync, EOL drop under CE low, then async reset mid-sync.
    do_reset();
    run(310);
    for (int i = 0; i < 10; i++) begin
      tick(1'b0);
      check("hold_hcnt",   32'(bus.HCNT),   32'd310);
      check("hold_hsyncl", 32'(bus.HSYNCL), 32'd0);
      check("hold_blank",  32'(bus.BLANK),  32'd1);
    end
    run(74);
    check("wrap_eol",  32'(bus.EOL),  32'd1);
    check("wrap_vcnt", 32'(bus.VCNT), 32'd1);
    tick(1'b0);
    check("eol_drop", 32'(bus.EOL),  32'd0);
    check("eol_hold", 32'(bus.HCNT), 32'd0);
    run(320);
    check("pre_rst_hsyncl", 32'(bus.HSYNCL), 32'd0);
    do_reset();
    tick(1'b1);
    check("post_rst_hcnt", 32'(bus.HCNT), 32'd1);
    check("post_rst_vcnt", 32'(bus.VCNT), 32'd0);

    // HLEN shrunk below the live count: run to 511, wrap, then short lines.
    do_reset();
    run(200);
    tick(1'b1, 1'b1, ADDR_HLEN, 9'd100);
    check("shrink_hcnt", 32'(bus.HCNT), 32'd201);
    run(310);
    check("shrink_top", 32'(bus.HCNT), 32'd511);
    check("shrink_top_eol", 32'(bus.EOL), 32'd0);
    tick(1'b1);
    check("shrink_wrap_h",   32'(bus.HCNT), 32'd0);
    check("shrink_wrap_eol", 32'(bus.EOL),  32'd1);
    check("shrink_wrap_v",   32'(bus.VCNT), 32'd1);
    run(100);
    check("short_line_100", 32'(bus.HCNT), 32'd100);
    tick(1'b1);
    check("short_wrap_h",   32'(bus.HCNT), 32'd0);
    check("short_wrap_eol", 32'(bus.EOL),  32'd1);
    check("short_wrap_v",   32'(bus.VCNT), 32'd2);

    // Full frame with 16-pixel lines: vertical sync, vertical blank, frame wrap.
    do_reset();
    tick(1'b0, 1'b1, ADDR_HLEN, 9'd15);
    for (int e = 1; e <= 4993; e++) begin
      tick(1'b1);
      case (e)
        3215: check("vblk_before", 32'(bus.BLANK), 32'd0);
        3216: check("vblk_rise",   32'(bus.BLANK), 32'd1);
        4015: check("vs_before",   {bus.VCNT, bus.VSYNCL}, {9'd250, 1'b1});
        4016: check("vs_fall",     {bus.VCNT, bus.VSYNCL, bus.EOL, bus.EOF}, {9'd251, 1'b0, 1'b1, 1'b0});
        4063: check("vs_last",     {bus.VCNT, bus.VSYNCL}, {9'd253, 1'b0});
        4064: check("vs_rise",     {bus.VCNT, bus.VSYNCL}, {9'd254, 1'b1});
        4991: check("frame_last",  {bus.HCNT, bus.VCNT, bus.EOF, bus.BLANK}, {9'd15, 9'd311, 1'b0, 1'b1});
        4992: check("frame_wrap",  {bus.HCNT, bus.VCNT, bus.EOL, bus.EOF, bus.BLANK},
                    {9'd0, 9'd0, 1'b1, 1'b1, 1'b0});
        4993: check("frame_after", {bus.HCNT, bus.EOL, bus.EOF}, {9'd1, 1'b0, 1'b0});
        default: ;
      endcase
    end

    // Equal sync start/end: clear wins, sync never asserts.
    do_reset();
    tick(1'b0, 1'b1, ADDR_HSS, 9'd50);
    tick(1'b0, 1'b1, ADDR_HSE, 9'd50);
    saw_low = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick(1'b1);
      if (!bus.HSYNCL) saw_low = 1'b1;
    end
    check("equal_cmp_hsyncl_low_seen", 32'(saw_low), 32'd0);

    // Randomized CE and register traffic against the model.
    do_reset();
    tick(1'b0, 1'b1, ADDR_HLEN, 9'd30);
    tick(1'b0, 1'b1, ADDR_VLEN, 9'd10);
    for (int i = 0; i < 15000; i++) begin
      logic [2:0] a;
      logic [8:0] d;
      bit w;
      a = 3'($urandom_range(0, 7));
      w = ($urandom_range(0, 39) == 0);
      if (a == ADDR_HLEN || a == ADDR_VLEN)
        d = ($urandom_range(0, 7) == 0) ? 9'($urandom_range(0, 511)) : 9'($urandom_range(4, 40));
      else
        d = 9'($urandom_range(0, 60));
      tick($urandom_range(0, 3) != 0, w, a, d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
